sword_arbiter: RTL

SWORD_ARBITER -- requirements
Module: sword_arbiter

---
 rtl/sword_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/sword_arbiter.sv
// Round-robin single-owner arbiter: IDLE -> HOLD -> COOLDOWN, all outputs registered.
// Optional hold timeout enabled by defining SWORD_ARB_TIMEOUT_EN.
module sword_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int HOLD_MAX    = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PLAYERS-1:0]         req,
    input  logic [NUM_PLAYERS-1:0]         rel,
    output logic [NUM_PLAYERS-1:0]         grant,
    output logic                           v,
    output logic [$clog2(NUM_PLAYERS)-1:0] owner,
    output logic                           timeout
);
    localparam int IW = $clog2(NUM_PLAYERS);

    if (NUM_PLAYERS != 4 || HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_param_check
        $error("sword_arbiter: NUM_PLAYERS must be 4 and HOLD_MAX 1..15");
    end

    typedef enum logic [1:0] {IDLE, HOLD, COOLDOWN} state_t;

    state_t                 state, state_nxt;
    logic [IW-1:0]          ptr, ptr_nxt, owner_nxt, winner, idx;
    logic [NUM_PLAYERS-1:0] grant_nxt;
    logic                   v_nxt, found, vol_end, tmo_hit;
    logic [3:0]             hold_cnt, hold_cnt_nxt;
`ifdef SWORD_ARB_TIMEOUT_EN
    logic                   timeout_nxt;
`endif

    // First requester at or after ptr; the 2-bit index wraps 3 -> 0 naturally.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = ptr;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            idx = ptr + IW'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        v_nxt        = v;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        // Release beats a still-asserted request.
        vol_end      = rel[owner] | ~req[owner];
`ifdef SWORD_ARB_TIMEOUT_EN
        tmo_hit      = (hold_cnt == 4'(HOLD_MAX - 1));
        timeout_nxt  = 1'b0;
`else
        tmo_hit      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt         = HOLD;
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                    v_nxt             = 1'b1;
                    owner_nxt         = winner;
                    hold_cnt_nxt      = 4'd0;
                end
            end
            HOLD: begin
                if (vol_end || tmo_hit) begin
                    state_nxt = COOLDOWN;
                    grant_nxt = '0;
                    v_nxt     = 1'b0;
                    ptr_nxt   = owner + IW'(1);
`ifdef SWORD_ARB_TIMEOUT_EN
                    // Pulse only when the hold was forced to end.
                    timeout_nxt = tmo_hit & ~vol_end;
`endif
                end else if (hold_cnt != 4'hF) begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            COOLDOWN: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            v        <= 1'b0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            v        <= v_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

`ifdef SWORD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout <= 1'b0;
        else       timeout <= timeout_nxt;
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
